// File: rtl/multicycle_controller.sv
// multicycle_controller: Moore control FSM for the shared multicycle MIPS
// datapath. One datapath step per cycle; memory states hold until memready,
// and a watchdog aborts an access that never completes.
module multicycle_controller #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       iord,
  output logic       memwrite,
  output logic       memreq,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [2:0] alucontrol,
  output logic [1:0] pcsrc,
  output logic       pcen,
  output logic       illegal,
  output logic       memerr
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWR  = 4'd4,
    S_MEMWB  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Value of the wait counter during the MAX_WAIT-th consecutive wait cycle.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [2:0]        aluhold_q, aluhold_d;

  logic [2:0] funct_alu_s;
  logic       funct_ok_s;
  logic       mem_state_s;
  logic       timeout_s;
  logic       pcwrite_s;
  logic       branch_s;
  logic       memwrite_s;
  logic       memreq_s;
  logic       irwrite_s;
  logic       regwrite_s;
  logic       illegal_s;
  logic       memerr_s;

  // State, watchdog counter and held R-type ALU op; reset forces FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_FETCH;
      wait_q    <= '0;
      aluhold_q <= ALU_ADD;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      aluhold_q <= aluhold_d;
    end
  end

  // R-type funct decode into an ALU operation plus a legality flag.
  always_comb begin
    funct_alu_s = ALU_ADD;
    funct_ok_s  = 1'b1;
    case (funct)
      6'b100000: funct_alu_s = ALU_ADD;
      6'b100010: funct_alu_s = ALU_SUB;
      6'b100100: funct_alu_s = ALU_AND;
      6'b100101: funct_alu_s = ALU_OR;
      6'b101010: funct_alu_s = ALU_SLT;
      default: begin
        funct_alu_s = ALU_ADD;
        funct_ok_s  = 1'b0;
      end
    endcase
  end

  // Watchdog fires only when a memory state has waited its full budget and
  // memready is still low; a late memready on that cycle wins.
  always_comb begin
    mem_state_s = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    timeout_s   = mem_state_s && !memready && (wait_q == WAIT_LAST);
  end

  // Next-state and raw (pre-reset-gating) control outputs for each state.
  always_comb begin
    state_d    = state_q;
    aluhold_d  = aluhold_q;
    iord       = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b01;
    alucontrol = ALU_ADD;
    pcsrc      = 2'b00;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    memwrite_s = 1'b0;
    memreq_s   = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    illegal_s  = 1'b0;
    memerr_s   = 1'b0;
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (memready) begin
          memreq_s  = 1'b1;
          irwrite_s = 1'b1;
          pcwrite_s = 1'b1;
          state_d   = S_DECODE;
        end else if (timeout_s) begin
          memerr_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          memreq_s = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_s = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        if (op == OP_SW) begin
          state_d = S_MEMWR;
        end else begin
          state_d = S_MEMRD;
        end
      end
      S_MEMRD: begin
        iord = 1'b1;
        if (memready) begin
          memreq_s = 1'b1;
          state_d  = S_MEMWB;
        end else if (timeout_s) begin
          memerr_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          memreq_s = 1'b1;
          state_d  = S_MEMRD;
        end
      end
      S_MEMWR: begin
        iord = 1'b1;
        if (memready) begin
          memreq_s   = 1'b1;
          memwrite_s = 1'b1;
          state_d    = S_FETCH;
        end else if (timeout_s) begin
          memerr_s = 1'b1;
          state_d  = S_FETCH;
        end else begin
          memreq_s   = 1'b1;
          memwrite_s = 1'b1;
          state_d    = S_MEMWR;
        end
      end
      S_MEMWB: begin
        regwrite_s = 1'b1;
        memtoreg   = 1'b1;
        state_d    = S_FETCH;
      end
      S_EXEC: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b00;
        alucontrol = funct_alu_s;
        aluhold_d  = funct_alu_s;
        if (funct_ok_s) begin
          state_d = S_ALUWB;
        end else begin
          illegal_s = 1'b1;
          state_d   = S_FETCH;
        end
      end
      S_ALUWB: begin
        // The IR may already be changing, so use the op captured in EXEC.
        alusrca    = 1'b1;
        alusrcb    = 2'b00;
        alucontrol = aluhold_q;
        regwrite_s = 1'b1;
        regdst     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b00;
        alucontrol = ALU_SUB;
        pcsrc      = 2'b01;
        branch_s   = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_s = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pcsrc     = 2'b10;
        pcwrite_s = 1'b1;
        state_d   = S_FETCH;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Watchdog counter: clears on any state change or abort, counts idle waits.
  always_comb begin
    if ((state_d != state_q) || timeout_s) begin
      wait_d = '0;
    end else if (mem_state_s && !memready) begin
      wait_d = wait_q + WAIT_W'(1);
    end else begin
      wait_d = '0;
    end
  end

  // Strobes are forced low while reset is high so nothing leaks out mid-abort.
  always_comb begin
    memwrite = memwrite_s & ~reset;
    memreq   = memreq_s & ~reset;
    irwrite  = irwrite_s & ~reset;
    regwrite = regwrite_s & ~reset;
    illegal  = illegal_s & ~reset;
    memerr   = memerr_s & ~reset;
    pcen     = (pcwrite_s | (branch_s & zero)) & ~reset;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: scoreboard bench for the multicycle controller.
// Each cycle's expected output vector (value + care mask) is queued when the
// inputs are driven and popped/compared once the outputs have settled.
module tb_multicycle_controller;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BAD  = 6'b111111;
  localparam logic [5:0] F_NONE  = 6'b000000;
  localparam logic [5:0] F_BAD   = 6'b111111;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memready;
  logic       iord, memwrite, memreq, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb;
  logic [2:0] alucontrol;
  logic [1:0] pcsrc;
  logic       pcen, illegal, memerr;

  logic [35:0] sb[$];
  int n_cmp = 0;
  int n_bad = 0;

  multicycle_controller #(.MAX_WAIT(15), .WAIT_W(8)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .iord(iord), .memwrite(memwrite), .memreq(memreq), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .alucontrol(alucontrol), .pcsrc(pcsrc), .pcen(pcen),
    .illegal(illegal), .memerr(memerr)
  );

  always #5 clk = ~clk;

  // Pack one output vector: iord,memwrite,memreq,irwrite,regdst,memtoreg,
  // regwrite,alusrca,alusrcb,alucontrol,pcsrc,pcen,illegal,memerr.
  function automatic logic [17:0] v(input logic a, b, c, d, e, f, g, h,
                                    input logic [1:0] asb, input logic [2:0] ac,
                                    input logic [1:0] ps, input logic pe, il, me);
    return {a, b, c, d, e, f, g, h, asb, ac, ps, pe, il, me};
  endfunction

  function automatic logic [17:0] outv();
    return {iord, memwrite, memreq, irwrite, regdst, memtoreg, regwrite, alusrca,
            alusrcb, alucontrol, pcsrc, pcen, illegal, memerr};
  endfunction

  // Care masks: strobes always, plus the selects each state defines.
  function automatic logic [17:0] m_strobe();
    return v(L, H, H, H, L, L, H, L, 2'b00, 3'b000, 2'b00, H, H, H);
  endfunction
  function automatic logic [17:0] m_alu();
    return m_strobe() | v(L, L, L, L, L, L, L, H, 2'b11, 3'b111, 2'b00, L, L, L);
  endfunction
  function automatic logic [17:0] m_wb();
    return m_strobe() | v(L, L, L, L, H, H, L, L, 2'b00, 3'b000, 2'b00, L, L, L);
  endfunction

  // Expected {value, mask} per state, written from the state descriptions.
  function automatic logic [35:0] x_fetch(input logic rdy);
    return {v(L, L, H, rdy, L, L, L, L, 2'b01, 3'b010, 2'b00, rdy, L, L),
            m_alu() | v(H, L, L, L, L, L, L, L, 2'b00, 3'b000, 2'b11, L, L, L)};
  endfunction
  function automatic logic [35:0] x_reset();
    return {v(L, L, L, L, L, L, L, L, 2'b01, 3'b010, 2'b00, L, L, L),
            m_alu() | v(H, L, L, L, L, L, L, L, 2'b00, 3'b000, 2'b11, L, L, L)};
  endfunction
  function automatic logic [35:0] x_decode(input logic ill);
    return {v(L, L, L, L, L, L, L, L, 2'b11, 3'b010, 2'b00, L, ill, L), m_alu()};
  endfunction
  function automatic logic [35:0] x_memadr();
    return {v(L, L, L, L, L, L, L, H, 2'b10, 3'b010, 2'b00, L, L, L), m_alu()};
  endfunction
  function automatic logic [35:0] x_memrd();
    return {v(H, L, H, L, L, L, L, L, 2'b00, 3'b000, 2'b00, L, L, L),
            m_strobe() | v(H, L, L, L, L, L, L, L, 2'b00, 3'b000, 2'b00, L, L, L)};
  endfunction
  function automatic logic [35:0] x_memwr();
    return {v(H, H, H, L, L, L, L, L, 2'b00, 3'b000, 2'b00, L, L, L),
            m_strobe() | v(H, L, L, L, L, L, L, L, 2'b00, 3'b000, 2'b00, L, L, L)};
  endfunction
  function automatic logic [35:0] x_memwb();
    return {v(L, L, L, L, L, H, H, L, 2'b00, 3'b000, 2'b00, L, L, L), m_wb()};
  endfunction
  function automatic logic [35:0] x_exec(input logic [2:0] ac);
    return {v(L, L, L, L, L, L, L, H, 2'b00, ac, 2'b00, L, L, L), m_alu()};
  endfunction
  function automatic logic [35:0] x_exec_bad();
    return {v(L, L, L, L, L, L, L, L, 2'b00, 3'b000, 2'b00, L, H, L), m_strobe()};
  endfunction
  function automatic logic [35:0] x_aluwb(input logic [2:0] ac);
    return {v(L, L, L, L, H, L, H, L, 2'b00, ac, 2'b00, L, L, L),
            m_wb() | v(L, L, L, L, L, L, L, L, 2'b00, 3'b111, 2'b00, L, L, L)};
  endfunction
  function automatic logic [35:0] x_branch(input logic z);
    return {v(L, L, L, L, L, L, L, H, 2'b00, 3'b110, 2'b01, z, L, L),
            m_alu() | v(L, L, L, L, L, L, L, L, 2'b00, 3'b000, 2'b11, L, L, L)};
  endfunction
  function automatic logic [35:0] x_addiex();
    return {v(L, L, L, L, L, L, L, H, 2'b10, 3'b010, 2'b00, L, L, L), m_alu()};
  endfunction
  function automatic logic [35:0] x_addiwb();
    return {v(L, L, L, L, L, L, H, L, 2'b00, 3'b000, 2'b00, L, L, L), m_wb()};
  endfunction
  function automatic logic [35:0] x_jump();
    return {v(L, L, L, L, L, L, L, L, 2'b00, 3'b000, 2'b10, H, L, L),
            m_strobe() | v(L, L, L, L, L, L, L, L, 2'b00, 3'b000, 2'b11, L, L, L)};
  endfunction
  function automatic logic [35:0] x_abort();
    return {v(L, L, L, L, L, L, L, L, 2'b00, 3'b000, 2'b00, L, L, H), m_strobe()};
  endfunction

  // One cycle record: {op, funct, zero, memready, expected{value,mask}}.
  function automatic logic [49:0] rec(input logic [5:0] o, f, input logic z, mr,
                                      input logic [35:0] e);
    return {o, f, z, mr, e};
  endfunction

  // Drive one cycle's inputs just after the falling edge and queue its expectation.
  task automatic drive(input logic [49:0] r);
    @(negedge clk);
    op       = r[49:44];
    funct    = r[43:38];
    zero     = r[37];
    memready = r[36];
    sb.push_back(r[35:0]);
  endtask

  task automatic test_reset();
    logic [35:0] e;
    logic [17:0] obs;
    for (int i = 0; i < 2; i++) begin
      drive(rec(OP_LW, F_NONE, H, H, x_reset()));
      #1; e = sb.pop_front(); obs = outv(); n_cmp++;
      if ((obs & e[17:0]) !== (e[35:18] & e[17:0])) begin
        n_bad++; $display("FAIL reset_hold c%0d: got %b want %b mask %b", i, obs, e[35:18], e[17:0]);
      end
    end
    memready = L;
    reset    = L;
    drive(rec(OP_LW, F_NONE, L, L, x_fetch(L)));
    #1; e = sb.pop_front(); obs = outv(); n_cmp++;
    if ((obs & e[17:0]) !== (e[35:18] & e[17:0])) begin
      n_bad++; $display("FAIL reset_release: got %b want %b mask %b", obs, e[35:18], e[17:0]);
    end
  endtask

  task automatic test_lw();
    logic [49:0] cyc[$];
    logic [35:0] e;
    logic [17:0] obs;
    cyc = '{rec(OP_LW, F_NONE, L, H, x_fetch(H)), rec(OP_LW, F_NONE, L, H, x_decode(L)),
            rec(OP_LW, F_NONE, L, H, x_memadr()), rec(OP_LW, F_NONE, L, H, x_memrd()),
            rec(OP_LW, F_NONE, L, H, x_memwb()), rec(OP_LW, F_NONE, L, L, x_fetch(L))};
    foreach (cyc[i]) begin
      drive(cyc[i]);
      #1; e = sb.pop_front(); obs = outv(); n_cmp++;
      if ((obs & e[17:0]) !== (e[35:18] & e[17:0])) begin
        n_bad++; $display("FAIL lw c%0d: got %b want %b mask %b", i, obs, e[35:18], e[17:0]);
      end
    end
  endtask

  task automatic test_sw_wait();
    logic [49:0] cyc[$];
    logic [35:0] e;
    logic [17:0] obs;
    cyc = '{rec(OP_SW, F_NONE, L, H, x_fetch(H)), rec(OP_SW, F_NONE, L, H, x_decode(L)),
            rec(OP_SW, F_NONE, L, H, x_memadr()), rec(OP_SW, F_NONE, L, L, x_memwr()),
            rec(OP_SW, F_NONE, L, L, x_memwr()), rec(OP_SW, F_NONE, L, L, x_memwr()),
            rec(OP_SW, F_NONE, L, H, x_memwr()), rec(OP_SW, F_NONE, L, L, x_fetch(L))};
    foreach (cyc[i]) begin
      drive(cyc[i]);
      #1; e = sb.pop_front(); obs = outv(); n_cmp++;
      if ((obs & e[17:0]) !== (e[35:18] & e[17:0])) begin
        n_bad++; $display("FAIL sw c%0d: got %b want %b mask %b", i, obs, e[35:18], e[17:0]);
      end
    end
  endtask

  task automatic test_beq();
    logic [49:0] cyc[$];
    logic [35:0] e;
    logic [17:0] obs;
    for (int z = 1; z >= 0; z--) begin
      cyc = '{rec(OP_BEQ, F_NONE, z[0], H, x_fetch(H)), rec(OP_BEQ, F_NONE, z[0], H, x_decode(L)),
              rec(OP_BEQ, F_NONE, z[0], H, x_branch(z[0])), rec(OP_BEQ, F_NONE, z[0], L, x_fetch(L))};
      foreach (cyc[i]) begin
        drive(cyc[i]);
        #1; e = sb.pop_front(); obs = outv(); n_cmp++;
        if ((obs & e[17:0]) !== (e[35:18] & e[17:0])) begin
          n_bad++; $display("FAIL beq z%0d c%0d: got %b want %b mask %b", z, i, obs, e[35:18], e[17:0]);
        end
      end
    end
  endtask

  task automatic test_rtype();
    logic [5:0]  fl[5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0]  al[5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
    logic [49:0] cyc[$];
    logic [35:0] e;
    logic [17:0] obs;
    for (int k = 0; k < 5; k++) begin
      // funct is scrambled during ALUWB: the op captured in EXEC must hold.
      cyc = '{rec(OP_R, fl[k], L, H, x_fetch(H)), rec(OP_R, fl[k], L, H, x_decode(L)),
              rec(OP_R, fl[k], L, H, x_exec(al[k])), rec(OP_R, F_BAD, L, H, x_aluwb(al[k])),
              rec(OP_R, fl[k], L, L, x_fetch(L))};
      foreach (cyc[i]) begin
        drive(cyc[i]);
        #1; e = sb.pop_front(); obs = outv(); n_cmp++;
        if ((obs & e[17:0]) !== (e[35:18] & e[17:0])) begin
          n_bad++; $display("FAIL rtype f%b c%0d: got %b want %b mask %b", fl[k], i, obs, e[35:18], e[17:0]);
        end
      end
    end
  endtask

  task automatic test_illegal();
    logic [49:0] cyc[$];
    logic [35:0] e;
    logic [17:0] obs;
    cyc = '{rec(OP_R, F_BAD, L, H, x_fetch(H)), rec(OP_R, F_BAD, L, H, x_decode(L)),
            rec(OP_R, F_BAD, L, H, x_exec_bad()), rec(OP_R, F_BAD, L, L, x_fetch(L)),
            rec(OP_BAD, F_NONE, L, H, x_fetch(H)), rec(OP_BAD, F_NONE, L, H, x_decode(H)),
            rec(OP_BAD, F_NONE, L, L, x_fetch(L))};
    foreach (cyc[i]) begin
      drive(cyc[i]);
      #1; e = sb.pop_front(); obs = outv(); n_cmp++;
      if ((obs & e[17:0]) !== (e[35:18] & e[17:0])) begin
        n_bad++; $display("FAIL illegal c%0d: got %b want %b mask %b", i, obs, e[35:18], e[17:0]);
      end
    end
  endtask

  task automatic test_addi_jump();
    logic [49:0] cyc[$];
    logic [35:0] e;
    logic [17:0] obs;
    cyc = '{rec(OP_ADDI, F_NONE, L, H, x_fetch(H)), rec(OP_ADDI, F_NONE, L, H, x_decode(L)),
            rec(OP_ADDI, F_NONE, L, H, x_addiex()), rec(OP_ADDI, F_NONE, L, H, x_addiwb()),
            rec(OP_J, F_NONE, L, H, x_fetch(H)), rec(OP_J, F_NONE, L, H, x_decode(L)),
            rec(OP_J, F_NONE, L, H, x_jump()), rec(OP_J, F_NONE, L, L, x_fetch(L))};
    foreach (cyc[i]) begin
      drive(cyc[i]);
      #1; e = sb.pop_front(); obs = outv(); n_cmp++;
      if ((obs & e[17:0]) !== (e[35:18] & e[17:0])) begin
        n_bad++; $display("FAIL addi_j c%0d: got %b want %b mask %b", i, obs, e[35:18], e[17:0]);
      end
    end
  endtask

  task automatic test_watchdog();
    logic [49:0] cyc[$];
    logic [35:0] e;
    logic [17:0] obs;
    // Run 1: memready stuck low, abort on the 15th wait cycle, then retry.
    // Run 2: memready arrives on the 15th wait cycle, normal completion.
    cyc = '{rec(OP_J, F_NONE, L, H, x_fetch(H)), rec(OP_J, F_NONE, L, H, x_decode(L)),
            rec(OP_J, F_NONE, L, H, x_jump())};
    for (int i = 0; i < 14; i++) cyc.push_back(rec(OP_J, F_NONE, L, L, x_fetch(L)));
    cyc.push_back(rec(OP_J, F_NONE, L, L, x_abort()));
    cyc.push_back(rec(OP_J, F_NONE, L, L, x_fetch(L)));
    cyc.push_back(rec(OP_J, F_NONE, L, H, x_fetch(H)));
    cyc.push_back(rec(OP_J, F_NONE, L, H, x_decode(L)));
    cyc.push_back(rec(OP_J, F_NONE, L, H, x_jump()));
    for (int i = 0; i < 14; i++) cyc.push_back(rec(OP_J, F_NONE, L, L, x_fetch(L)));
    cyc.push_back(rec(OP_J, F_NONE, L, H, x_fetch(H)));
    cyc.push_back(rec(OP_J, F_NONE, L, H, x_decode(L)));
    cyc.push_back(rec(OP_J, F_NONE, L, H, x_jump()));
    foreach (cyc[i]) begin
      drive(cyc[i]);
      #1; e = sb.pop_front(); obs = outv(); n_cmp++;
      if ((obs & e[17:0]) !== (e[35:18] & e[17:0])) begin
        n_bad++; $display("FAIL watchdog c%0d: got %b want %b mask %b", i, obs, e[35:18], e[17:0]);
      end
    end
  endtask

  task automatic test_reset_midinstr();
    logic [49:0] cyc[$];
    logic [35:0] e;
    logic [17:0] obs;
    cyc = '{rec(OP_R, 6'b100000, L, H, x_fetch(H)), rec(OP_R, 6'b100000, L, H, x_decode(L)),
            rec(OP_R, 6'b100000, L, H, x_exec(3'b010)), rec(OP_R, 6'b100000, L, H, x_aluwb(3'b010))};
    foreach (cyc[i]) begin
      drive(cyc[i]);
      #1; e = sb.pop_front(); obs = outv(); n_cmp++;
      if ((obs & e[17:0]) !== (e[35:18] & e[17:0])) begin
        n_bad++; $display("FAIL midreset_pre c%0d: got %b want %b mask %b", i, obs, e[35:18], e[17:0]);
      end
    end
    // Assert reset between edges while still in ALUWB: strobes must drop now.
    #1; reset = H;
    sb.push_back(x_reset());
    #1; e = sb.pop_front(); obs = outv(); n_cmp++;
    if ((obs & e[17:0]) !== (e[35:18] & e[17:0])) begin
      n_bad++; $display("FAIL midreset_async: got %b want %b mask %b", obs, e[35:18], e[17:0]);
    end
    drive(rec(OP_R, 6'b100000, L, H, x_reset()));
    #1; e = sb.pop_front(); obs = outv(); n_cmp++;
    if ((obs & e[17:0]) !== (e[35:18] & e[17:0])) begin
      n_bad++; $display("FAIL midreset_hold: got %b want %b mask %b", obs, e[35:18], e[17:0]);
    end
    memready = L;
    reset    = L;
    cyc = '{rec(OP_R, 6'b100000, L, L, x_fetch(L)), rec(OP_R, 6'b100000, L, H, x_fetch(H)),
            rec(OP_R, 6'b100000, L, H, x_decode(L))};
    foreach (cyc[i]) begin
      drive(cyc[i]);
      #1; e = sb.pop_front(); obs = outv(); n_cmp++;
      if ((obs & e[17:0]) !== (e[35:18] & e[17:0])) begin
        n_bad++; $display("FAIL midreset_post c%0d: got %b want %b mask %b", i, obs, e[35:18], e[17:0]);
      end
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  // Test sequence.
  initial begin
    reset    = H;
    op       = OP_LW;
    funct    = F_NONE;
    zero     = L;
    memready = H;
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_rtype();
    test_illegal();
    test_addi_jump();
    test_watchdog();
    test_reset_midinstr();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
